// File: rtl/qea_pkg.sv
// Shared types for the QEA host sequencer: FSM state encoding and complex-word width.
package qea_pkg;

  localparam int CPLX_WIDTH = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CTX,
    S_LOAD_ST,
    S_START,
    S_RUN,
    S_READ,
    S_DONE
  } state_e;

endpackage

// File: rtl/qea_rd_skid.sv
// Readback path: delays each read strobe by RD_LAT cycles, then parks the RAM row in a
// single-entry holding register until the consumer accepts it.
module qea_rd_skid #(
  parameter int RD_LAT    = 1,
  parameter int ROW_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_issue,
  input  logic [ROW_WIDTH-1:0] i_dout,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [ROW_WIDTH-1:0] o_data,
  output logic                 o_idle
);

  logic [RD_LAT-1:0]    pend_q;
  logic                 hold_valid_q;
  logic [ROW_WIDTH-1:0] hold_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      hold_valid_q <= 1'b0;
      // NOTE: the holding register is reset as well, so o_rd_data reads 0 under reset.
      hold_data_q  <= '0;
    end else begin
      pend_q[0] <= i_issue;
      for (int i = 1; i < RD_LAT; i++) pend_q[i] <= pend_q[i-1];
      // Only one row is ever in flight, so capture and pop never coincide.
      if (pend_q[RD_LAT-1]) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= i_dout;
      end else if (hold_valid_q && i_ready) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign o_valid = hold_valid_q;
  assign o_data  = hold_data_q;
  assign o_idle  = !hold_valid_q && (pend_q == '0);

endmodule

// File: rtl/qea_host_seq.sv
// Host sequencer for a QEA core: loads context and state, starts the run, reads the state back.
// Define QEA_HOST_SEQ_CYCLE_CNT_EN to expose o_exec_cycles (RUN cycle count of the last job).
module qea_host_seq
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = CPLX_WIDTH / 2,
  parameter int NUM_FRAC_BIT     = 30,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int CTX_ADDR_WIDTH   = 16,
  parameter int RD_LAT           = 1,
  parameter int TIMEOUT          = 2**20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_cfg_valid,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [CTX_ADDR_WIDTH-1:0]          i_ctx_num,
  input  logic                               i_init_mode,
  input  logic                               i_ctx_valid,
  output logic                               o_ctx_ready,
  input  logic [2*DATA_WIDTH-1:0]            i_ctx_data,
  input  logic                               i_st_valid,
  output logic                               o_st_ready,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_st_data,
  output logic                               o_rd_valid,
  input  logic                               i_rd_ready,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_rd_data,
  output logic                               o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [CTX_ADDR_WIDTH-1:0]          o_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]            o_ctx_data,
  output logic [PE_NUM-1:0]                  o_state_ena,
  output logic [PE_NUM-1:0]                  o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_state_dina,
  input  logic                               i_qea_complete,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_qea_dout,
`ifdef QEA_HOST_SEQ_CYCLE_CNT_EN
  output logic [31:0]                        o_exec_cycles,
`endif
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_timeout,
  output logic                               o_cfg_err
);

  localparam int RW        = PE_NUM * 2 * DATA_WIDTH;
  localparam int RUN_CNT_W = $clog2(TIMEOUT + 1);
  // |0>: real part of the most-significant PE slice of row 0 equals 1.0.
  localparam logic [RW-1:0] ROW0_INIT = RW'(1) << (RW - DATA_WIDTH + NUM_FRAC_BIT);

  state_e                        state_q;
  logic [MAX_QBIT_WIDTH-1:0]     qbit_q;
  logic [CTX_ADDR_WIDTH-1:0]     ctx_last_q, ctx_addr_q;
  logic [STATE_ADDR_WIDTH-1:0]   row_last_q, row_addr_q, row_last_d;
  logic                          init_mode_q, rd_all_q, timeout_q, cfg_err_q;
  logic [RUN_CNT_W-1:0]          run_cnt_q;
  logic [31:0]                   qdiff;
  logic                          cfg_bad, ctx_wr, st_wr, rd_issue, skid_idle, start_entry;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    qdiff      = 32'(i_qbit_num) - 32'(PE_NUM_WIDTH);
    cfg_bad    = (32'(i_qbit_num) > 32'(PE_NUM_WIDTH)) && (qdiff >= 32'(STATE_ADDR_WIDTH));
    row_last_d = '0;
    if ((32'(i_qbit_num) > 32'(PE_NUM_WIDTH)) && !cfg_bad)
      row_last_d = (STATE_ADDR_WIDTH'(1) << qdiff) - STATE_ADDR_WIDTH'(1);
  end

  assign o_ctx_ready = (state_q == S_LOAD_CTX);
  assign o_st_ready  = (state_q == S_LOAD_ST) && init_mode_q;
  assign ctx_wr      = o_ctx_ready && i_ctx_valid;
  assign st_wr       = (state_q == S_LOAD_ST) && (init_mode_q ? i_st_valid : 1'b1);
  assign rd_issue    = (state_q == S_READ) && skid_idle && !rd_all_q;
  assign start_entry = st_wr && (row_addr_q == row_last_q);

  assign o_ctx_en      = ctx_wr;
  assign o_ctx_wea     = ctx_wr;
  assign o_ctx_addr    = ctx_wr ? ctx_addr_q : '0;
  assign o_ctx_data    = ctx_wr ? i_ctx_data : '0;
  assign o_state_ena   = {PE_NUM{st_wr || rd_issue}};
  assign o_state_wea   = {PE_NUM{st_wr}};
  assign o_state_addra = (st_wr || rd_issue) ? row_addr_q : '0;

  always_comb begin
    o_state_dina = '0;
    if (st_wr) begin
      if (init_mode_q)             o_state_dina = i_st_data;
      else if (row_addr_q == '0)   o_state_dina = ROW0_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qbit_q      <= '0;
      ctx_last_q  <= '0;
      ctx_addr_q  <= '0;
      row_last_q  <= '0;
      row_addr_q  <= '0;
      init_mode_q <= 1'b0;
      rd_all_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      cfg_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_cfg_valid) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              qbit_q      <= i_qbit_num;
              ctx_last_q  <= i_ctx_num - CTX_ADDR_WIDTH'(1);
              init_mode_q <= i_init_mode;
              row_last_q  <= row_last_d;
              ctx_addr_q  <= '0;
              row_addr_q  <= '0;
              rd_all_q    <= 1'b0;
              timeout_q   <= 1'b0;
              state_q     <= (i_ctx_num == '0) ? S_LOAD_ST : S_LOAD_CTX;
            end
          end
        end
        S_LOAD_CTX: begin
          if (ctx_wr) begin
            if (ctx_addr_q == ctx_last_q) state_q    <= S_LOAD_ST;
            else                          ctx_addr_q <= ctx_addr_q + 1'b1;
          end
        end
        S_LOAD_ST: begin
          if (start_entry) begin
            row_addr_q <= '0;
            run_cnt_q  <= '0;
            state_q    <= S_START;
          end else if (st_wr) begin
            row_addr_q <= row_addr_q + 1'b1;
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 1'b1;
          if (i_qea_complete) begin
            state_q <= S_READ;
          end else if (run_cnt_q == RUN_CNT_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            if (row_addr_q == row_last_q) rd_all_q   <= 1'b1;
            else                          row_addr_q <= row_addr_q + 1'b1;
          end else if (rd_all_q && skid_idle) begin
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  qea_rd_skid #(
    .RD_LAT    (RD_LAT),
    .ROW_WIDTH (RW)
  ) u_rd_skid (
    .clk     (clk),
    .rst     (rst),
    .i_issue (rd_issue),
    .i_dout  (i_qea_dout),
    .i_ready (i_rd_ready),
    .o_valid (o_rd_valid),
    .o_data  (o_rd_data),
    .o_idle  (skid_idle)
  );

  assign o_qea_start    = (state_q == S_START);
  assign o_qea_qbit_num = qbit_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_timeout      = timeout_q;
  assign o_cfg_err      = cfg_err_q;

`ifdef QEA_HOST_SEQ_CYCLE_CNT_EN
  assign o_exec_cycles = 32'(run_cnt_q);
`endif

endmodule

// File: tb/tb_qea_host_seq.sv
// Scoreboard bench for qea_host_seq: stimulus pushes expected writes/rows/pulses into queues,
// a monitor pops and compares them whenever the DUT presents the matching output.
module tb_qea_host_seq;

  localparam int RW = 256;
  localparam logic [RW-1:0] ROW0 = {64'h4000_0000_0000_0000, 192'd0};
  localparam int EV_START = 1, EV_DONE = 2, EV_DONE_TO = 3, EV_CFG = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_cfg_valid, i_init_mode, i_ctx_valid, i_st_valid, i_rd_ready, i_qea_complete;
  logic [5:0]    i_qbit_num;
  logic [15:0]   i_ctx_num;
  logic [63:0]   i_ctx_data;
  logic [RW-1:0] i_st_data, i_qea_dout;
  logic          o_ctx_ready, o_st_ready, o_rd_valid, o_qea_start, o_ctx_en, o_ctx_wea;
  logic [RW-1:0] o_rd_data, o_state_dina;
  logic [5:0]    o_qea_qbit_num;
  logic [15:0]   o_ctx_addr, o_state_addra;
  logic [63:0]   o_ctx_data;
  logic [3:0]    o_state_ena, o_state_wea;
  logic          o_busy, o_done, o_timeout, o_cfg_err;
`ifdef QEA_HOST_SEQ_CYCLE_CNT_EN
  logic [31:0]   o_exec_cycles;
`endif

  qea_host_seq #(.RD_LAT(2), .TIMEOUT(100)) dut (
`ifdef QEA_HOST_SEQ_CYCLE_CNT_EN
    .o_exec_cycles (o_exec_cycles),
`endif
    .clk (clk), .rst (rst),
    .i_cfg_valid (i_cfg_valid), .i_qbit_num (i_qbit_num), .i_ctx_num (i_ctx_num),
    .i_init_mode (i_init_mode),
    .i_ctx_valid (i_ctx_valid), .o_ctx_ready (o_ctx_ready), .i_ctx_data (i_ctx_data),
    .i_st_valid (i_st_valid), .o_st_ready (o_st_ready), .i_st_data (i_st_data),
    .o_rd_valid (o_rd_valid), .i_rd_ready (i_rd_ready), .o_rd_data (o_rd_data),
    .o_qea_start (o_qea_start), .o_qea_qbit_num (o_qea_qbit_num),
    .o_ctx_en (o_ctx_en), .o_ctx_wea (o_ctx_wea), .o_ctx_addr (o_ctx_addr), .o_ctx_data (o_ctx_data),
    .o_state_ena (o_state_ena), .o_state_wea (o_state_wea), .o_state_addra (o_state_addra),
    .o_state_dina (o_state_dina),
    .i_qea_complete (i_qea_complete), .i_qea_dout (i_qea_dout),
    .o_busy (o_busy), .o_done (o_done), .o_timeout (o_timeout), .o_cfg_err (o_cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [79:0]      ctx_q[$];
  logic [271:0]     st_q[$];
  logic [RW-1:0]    rd_q[$];
  int               ev_q[$];
  logic             rdy_toggle = 1'b0;
  logic [RW-1:0]    ram_p0 = '0, ram_p1 = '0;

  function automatic logic [63:0] ctx_pat(input int k);
    return {32'hC0DE_0000 + 32'(k), 32'h1234_0000 + 32'(k)};
  endfunction

  function automatic logic [RW-1:0] row_pat(input logic [15:0] a);
    return {4{32'hB000_0000 + 32'(a), 32'hA000_0000 + 32'(a)}};
  endfunction

  function automatic logic [RW-1:0] st_pat(input int k);
    return {8{32'h5A5A_0000 + 32'(k)}};
  endfunction

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an output expected none", name);
  endtask

  task automatic pop_ev(input string name, input int got);
    if (ev_q.size() == 0) unexpected(name);
    else check(name, got, ev_q.pop_front());
  endtask

  // State RAM model: a read strobed in cycle t returns its row during cycle t+2.
  always begin
    @(negedge clk);
    #1;
    i_qea_dout = ram_p1;
    ram_p1     = ram_p0;
    ram_p0     = (o_state_ena[0] && !o_state_wea[0]) ? row_pat(o_state_addra) : '0;
  end

  always begin
    @(negedge clk);
    if (rdy_toggle) i_rd_ready = ~i_rd_ready;
  end

  // Monitor: compares every DUT output event against the head of its queue.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (o_ctx_en) begin
        if (ctx_q.size() == 0) unexpected("ctx_wr");
        else check("ctx_wr", {o_ctx_wea, o_ctx_addr, o_ctx_data}, {1'b1, ctx_q.pop_front()});
      end
      if (o_state_wea != '0) begin
        if (st_q.size() == 0) unexpected("st_wr");
        else check("st_wr", {o_state_ena, o_state_wea, o_state_addra, o_state_dina},
                   {8'hFF, st_q.pop_front()});
      end else if (o_state_ena != '0) begin
        check("rd_ena", o_state_ena, 4'hF);
      end
      if (o_rd_valid && i_rd_ready) begin
        if (rd_q.size() == 0) unexpected("rd_row");
        else check("rd_row", o_rd_data, rd_q.pop_front());
      end
      if (o_qea_start) pop_ev("start_pulse", EV_START);
      if (o_done)      pop_ev("done_pulse", o_timeout ? EV_DONE_TO : EV_DONE);
      if (o_cfg_err)   pop_ev("cfg_err_pulse", EV_CFG);
    end
  end

  task automatic check_all_zero(input string name);
    logic any;
    any = o_ctx_ready | o_st_ready | o_rd_valid | (|o_rd_data) | o_qea_start | (|o_qea_qbit_num)
        | o_ctx_en | o_ctx_wea | (|o_ctx_addr) | (|o_ctx_data) | (|o_state_ena) | (|o_state_wea)
        | (|o_state_addra) | (|o_state_dina) | o_busy | o_done | o_timeout | o_cfg_err;
`ifdef QEA_HOST_SEQ_CYCLE_CNT_EN
    any = any | (|o_exec_cycles);
`endif
    check(name, any, 1'b0);
  endtask

  task automatic check_exec(input string name, input int exp);
`ifdef QEA_HOST_SEQ_CYCLE_CNT_EN
    check(name, o_exec_cycles, exp);
`endif
  endtask

  task automatic start_job(input int qbit, input int ctxn, input logic mode);
    int n = 0;
    while (o_busy && n < 500) begin @(negedge clk); n++; end
    check("idle_before_cfg", o_busy, 1'b0);
    i_cfg_valid = 1'b1;
    i_qbit_num  = 6'(qbit);
    i_ctx_num   = 16'(ctxn);
    i_init_mode = mode;
    @(negedge clk);
    i_cfg_valid = 1'b0;
  endtask

  task automatic send_ctx(input logic [63:0] d);
    int n = 0;
    i_ctx_valid = 1'b1;
    i_ctx_data  = d;
    while (!o_ctx_ready && n < 200) begin @(negedge clk); n++; end
    check("ctx_ready", o_ctx_ready, 1'b1);
    @(negedge clk);
    i_ctx_valid = 1'b0;
  endtask

  task automatic send_st(input logic [RW-1:0] d);
    int n = 0;
    i_st_valid = 1'b1;
    i_st_data  = d;
    while (!o_st_ready && n < 200) begin @(negedge clk); n++; end
    check("st_ready", o_st_ready, 1'b1);
    @(negedge clk);
    i_st_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!o_qea_start && n < 300) begin @(negedge clk); n++; end
    check("start_seen", o_qea_start, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 500) begin @(negedge clk); n++; end
    check("done_seen", o_done, 1'b1);
  endtask

  task automatic pulse_complete(input int after_start);
    repeat (after_start) @(negedge clk);
    i_qea_complete = 1'b1;
    @(negedge clk);
    i_qea_complete = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_cfg_valid = 1'b0; i_qbit_num = '0; i_ctx_num = '0; i_init_mode = 1'b0;
    i_ctx_valid = 1'b0; i_ctx_data = '0; i_st_valid = 1'b0; i_st_data = '0;
    i_rd_ready = 1'b1; i_qea_complete = 1'b0; i_qea_dout = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // Job 1: 3 qubits, 85 context words, generated |0>, complete 40 cycles after start.
    for (int k = 0; k < 85; k++) ctx_q.push_back({16'(k), ctx_pat(k)});
    st_q.push_back({16'd0, ROW0});
    st_q.push_back({16'd1, 256'd0});
    ev_q.push_back(EV_START);
    rd_q.push_back(row_pat(16'd0));
    rd_q.push_back(row_pat(16'd1));
    ev_q.push_back(EV_DONE);
    start_job(3, 85, 1'b0);
    for (int k = 0; k < 85; k++) send_ctx(ctx_pat(k));
    wait_start();
    check("qbit_latched", o_qea_qbit_num, 6'd3);
    i_cfg_valid = 1'b1;
    i_qbit_num  = 6'd2;
    i_ctx_num   = 16'd0;
    @(negedge clk);
    i_cfg_valid = 1'b0;
    pulse_complete(39);
    wait_done();
    check_exec("exec_40", 40);

    // Job 2: 4 rows read back under 0/1 toggling backpressure.
    for (int r = 0; r < 4; r++) begin
      st_q.push_back({16'(r), (r == 0) ? ROW0 : 256'd0});
      rd_q.push_back(row_pat(16'(r)));
    end
    ev_q.push_back(EV_START);
    ev_q.push_back(EV_DONE);
    rdy_toggle = 1'b1;
    start_job(4, 0, 1'b0);
    wait_start();
    pulse_complete(5);
    wait_done();
    check_exec("exec_5", 5);
    rdy_toggle = 1'b0;
    @(negedge clk);
    i_rd_ready = 1'b1;

    // Completion outside RUN is ignored.
    i_qea_complete = 1'b1;
    @(negedge clk);
    i_qea_complete = 1'b0;
    @(negedge clk);
    check("complete_in_idle", o_busy, 1'b0);

    // Job 3: 1 qubit -> one row, QEA never completes -> timeout after 100 RUN cycles.
    ctx_q.push_back({16'd0, ctx_pat(7)});
    st_q.push_back({16'd0, ROW0});
    ev_q.push_back(EV_START);
    ev_q.push_back(EV_DONE_TO);
    start_job(1, 1, 1'b0);
    send_ctx(ctx_pat(7));
    wait_done();
    check("timeout_flag", o_timeout, 1'b1);
    check_exec("exec_100", 100);
    @(negedge clk);

    // Job 4: oversized qubit counts are rejected with a single error pulse.
    ev_q.push_back(EV_CFG);
    start_job(20, 0, 1'b0);
    check("cfg20_busy", o_busy, 1'b0);
    repeat (3) @(negedge clk);
    check("cfg20_busy_later", o_busy, 1'b0);
    ev_q.push_back(EV_CFG);
    start_job(18, 0, 1'b0);
    check("cfg18_busy", o_busy, 1'b0);
    @(negedge clk);

    // Job 5: reset in the middle of LOAD_ST aborts without any status pulse.
    for (int r = 0; r < 8; r++) st_q.push_back({16'(r), (r == 0) ? ROW0 : 256'd0});
    start_job(5, 0, 1'b0);
    begin
      int n = 0;
      while (o_state_wea == '0 && n < 50) begin @(negedge clk); n++; end
    end
    check("load_st_seen", o_state_wea, 4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midjob_reset_outputs");
    repeat (2) @(negedge clk);
    st_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy", o_busy, 1'b0);

    // Job 6: streamed state, 2 context words, normal completion after reset.
    ctx_q.push_back({16'd0, ctx_pat(20)});
    ctx_q.push_back({16'd1, ctx_pat(21)});
    st_q.push_back({16'd0, st_pat(0)});
    st_q.push_back({16'd1, st_pat(1)});
    ev_q.push_back(EV_START);
    rd_q.push_back(row_pat(16'd0));
    rd_q.push_back(row_pat(16'd1));
    ev_q.push_back(EV_DONE);
    start_job(3, 2, 1'b1);
    send_ctx(ctx_pat(20));
    send_ctx(ctx_pat(21));
    send_st(st_pat(0));
    send_st(st_pat(1));
    wait_start();
    pulse_complete(3);
    wait_done();
    check_exec("exec_3", 3);

    repeat (10) @(negedge clk);
    check("ctx_q_left", ctx_q.size(), 0);
    check("st_q_left", st_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    check("ev_q_left", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/qea_host_seq.md
QEA_HOST_SEQ -- requirements
Module: qea_host_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PE_NUM_WIDTH, 2, log2 of the PE count.
- PE_NUM, 4, PE count (2**PE_NUM_WIDTH).
- DATA_WIDTH, 32, width of the real and of the imaginary part.
- NUM_FRAC_BIT, 30, fixed-point fraction bits.
- MAX_QBIT_WIDTH, 6, width of the qubit count.
- STATE_ADDR_WIDTH, 16, state RAM row address width.
- CTX_ADDR_WIDTH, 16, context RAM address width.
- RD_LAT, 1, state RAM read latency in cycles (1..4).
- TIMEOUT, 2**20, maximum RUN cycles.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- i_cfg_valid  in  1  job request pulse, accepted only in IDLE.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count.
- i_ctx_num  in  CTX_ADDR_WIDTH  context word count (0 = no context load).
- i_init_mode  in  1  0 = generate |0>, 1 = stream the state.
- i_ctx_valid/o_ctx_ready  in/out  1  context stream handshake.
- i_ctx_data  in  2*DATA_WIDTH  context word.
- i_st_valid/o_st_ready  in/out  1  state stream handshake.
- i_st_data  in  PE_NUM*2*DATA_WIDTH  one state row.
- o_rd_valid/i_rd_ready  out/in  1  readback handshake.
- o_rd_data  out  PE_NUM*2*DATA_WIDTH  readback row.
- o_qea_start, o_qea_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena[PE_NUM], o_state_wea[PE_NUM], o_state_addra, o_state_dina  out  -  drive the QEA load and start ports.
- i_qea_complete  in  1  QEA done.
- i_qea_dout  in  PE_NUM*2*DATA_WIDTH  QEA state RAM read data.
- o_busy, o_done, o_timeout, o_cfg_err  out  1  status outputs.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_CTX, LOAD_ST, START, RUN, READ and DONE.
REQ-004 The row count SHALL be ROWS = 2**(i_qbit_num-PE_NUM_WIDTH) when i_qbit_num > PE_NUM_WIDTH, and 1 otherwise; it SHALL be latched with the other configuration inputs on acceptance.
REQ-005 If i_qbit_num-PE_NUM_WIDTH >= STATE_ADDR_WIDTH, the block SHALL pulse o_cfg_err for 1 cycle and stay in IDLE.
REQ-006 In LOAD_CTX, o_ctx_ready SHALL be 1.
- Each handshake SHALL write i_ctx_data at addresses 0..i_ctx_num-1 in the same cycle (o_ctx_en = o_ctx_wea = 1).
- If i_ctx_num = 0, the FSM SHALL skip to LOAD_ST.
REQ-007 In LOAD_ST with i_init_mode = 1, each i_st handshake SHALL write one row to addresses 0..ROWS-1 with all o_state_ena/o_state_wea bits set.
REQ-008 In LOAD_ST with i_init_mode = 0, the block SHALL write ROWS rows, one per cycle, without handshake.
- Row 0: the most-significant PE slice holds real = 2**NUM_FRAC_BIT (upper DATA_WIDTH bits) and imaginary = 0.
- All other bits and rows are zero.
REQ-009 START SHALL pulse o_qea_start for exactly 1 cycle, then enter RUN.
REQ-010 RUN SHALL wait for i_qea_complete and then enter READ.
- At TIMEOUT cycles, o_timeout SHALL go to 1 and the FSM SHALL enter DONE without readback.
REQ-011 READ SHALL issue read addresses 0..ROWS-1 with o_state_wea = 0.
- o_rd_data SHALL be captured RD_LAT cycles after each address.
- At most one row SHALL be outstanding, so i_rd_ready backpressure never drops or duplicates a row.
REQ-012 DONE SHALL hold o_done = 1 for 1 cycle and return to IDLE.
REQ-013 o_busy SHALL be 1 in every state except IDLE.
REQ-014 i_cfg_valid SHALL be ignored while busy.
REQ-015 i_qea_complete SHALL be ignored outside RUN.
REQ-016 Address counters SHALL not wrap: the last address is ROWS-1 or i_ctx_num-1.

Reset
REQ-017 While rst = 1, the FSM SHALL be in IDLE and all outputs SHALL be 0, including every address, data, strobe and o_exec_cycles.
REQ-018 Reset asserted mid-job SHALL abort the job; no partial-job status pulse SHALL follow.

Configuration
REQ-019 With QEA_HOST_SEQ_CYCLE_CNT_EN defined, output o_exec_cycles[31:0] SHALL count RUN cycles.
- It clears on entry to START and holds its value until the next job.
- Without the macro, the port and the counter SHALL be absent.

Structure
REQ-020 Package qea_pkg SHALL hold the FSM state enum and the complex-word width localparam.
REQ-021 A sub-module qea_rd_skid SHALL implement the RD_LAT alignment and the single-entry readback holding register.

Verification
REQ-022 Scenario: 3 qubits, PE_NUM 4, i_ctx_num 85, i_init_mode 0 -> 85 context writes at addresses 0..84, then 2 state writes with row0 = {64'h40000000_00000000, 0, 0, 0}, then one start pulse.
REQ-023 Scenario: i_qea_complete asserted 40 cycles after start, i_rd_ready held 1 -> 2 readback rows in address order, then an o_done pulse; o_exec_cycles = 40 when enabled.
REQ-024 Scenario: i_rd_ready toggled 0/1 every cycle with RD_LAT = 2 -> every row delivered exactly once, in order.
REQ-025 Scenario: i_qea_complete never asserted, TIMEOUT = 100 -> o_timeout = 1 after 100 RUN cycles, no o_rd_valid, o_done pulse.
REQ-026 Scenario: i_qbit_num = 1 -> 1 row; i_qbit_num = 20 with STATE_ADDR_WIDTH = 16 -> o_cfg_err pulse, o_busy stays 0.
REQ-027 Scenario: rst asserted during LOAD_ST -> all outputs 0 immediately; a new job afterwards completes normally.
